// File: rtl/dma_pcis_wrstrb_gen_pkg.sv
// Shared types and helpers for the PCIS write-strobe generator.
package dma_pcis_wrstrb_gen_pkg;

    localparam int unsigned DMA_PCIS_BYTES = 64;
    localparam int unsigned DMA_LANE_W     = 6;

    typedef logic [63:0]  DmaStrb;
    typedef logic [511:0] DmaLine;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } DmaWrGenState;

    // Thermometer mask: bit i set for every lane i >= lane.
    function automatic DmaStrb strb_from_lane(input logic [5:0] lane);
        DmaStrb m;
        for (int unsigned i = 0; i < DMA_PCIS_BYTES; i++) begin
            m[i] = (6'(i) >= lane);
        end
        return m;
    endfunction

    // Thermometer mask: bit i set for every lane i <= lane.
    function automatic DmaStrb strb_upto_lane(input logic [5:0] lane);
        DmaStrb m;
        for (int unsigned i = 0; i < DMA_PCIS_BYTES; i++) begin
            m[i] = (6'(i) <= lane);
        end
        return m;
    endfunction

    // Widen a per-lane mask to a per-bit mask over a whole line.
    function automatic DmaLine expand_strb(input DmaStrb s);
        DmaLine m;
        for (int unsigned i = 0; i < DMA_PCIS_BYTES; i++) begin
            m[i*8 +: 8] = {8{s[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dma_pcis_byte_rotate.sv
// Combinational 64-lane byte rotate: output lane j takes input lane (j - amt) mod 64.
module dma_pcis_byte_rotate
    import dma_pcis_wrstrb_gen_pkg::*;
(
    input  logic [511:0] data_i,
    input  logic [5:0]   amt_i,
    output logic [511:0] data_o
);

    // Each output lane selects its source lane with wrap-around in 6 bits.
    always_comb begin
        data_o = '0;
        for (int unsigned j = 0; j < DMA_PCIS_BYTES; j++) begin
            data_o[j*8 +: 8] = data_i[{6'(6'(j) - amt_i), 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/dma_pcis_wrstrb_gen.sv
// Realigns a dense byte-0-aligned source stream onto 64B destination lines
// starting at an arbitrary lane offset, producing byte strobes per beat.
module dma_pcis_wrstrb_gen
    import dma_pcis_wrstrb_gen_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [5:0]       cmd_offset,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_grant,
    input  logic [511:0]     packet_in,
    input  logic             packet_in_valid,
    output logic             packet_in_grant,
    output logic [511:0]     packet_out,
    output logic [63:0]      wrstrb_out,
    output logic             packet_out_last,
    output logic             packet_out_valid,
    input  logic             packet_out_grant
);

    localparam int unsigned SUM_W = LEN_W + 1;
    localparam int unsigned CNT_W = SUM_W - DMA_LANE_W;

    DmaWrGenState     state_q;
    logic [5:0]       offset_q;
    logic [5:0]       end_lane_q;
    logic [CNT_W-1:0] in_left_q;
    logic [CNT_W-1:0] out_left_q;
    logic             first_q;
    DmaLine           carry_q;
    DmaLine           out_data_q;
    DmaStrb           out_strb_q;
    logic             out_last_q;
    logic             out_valid_q;

    logic [SUM_W-1:0] len_ext;
    logic [SUM_W-1:0] span;
    logic [CNT_W-1:0] in_beats;
    logic [CNT_W-1:0] out_beats;
    logic [5:0]       end_lane_d;
    logic             cmd_fire;
    logic             out_free;
    logic             in_fire;
    DmaLine           rot;
    DmaStrb           hi_strb;
    DmaLine           hi_mask;
    DmaStrb           stream_strb;
    DmaLine           stream_data;
    DmaLine           flush_data;
    DmaStrb           flush_strb;

    // Command geometry: beat counts and final lane, computed one bit wider than the length.
    assign len_ext    = SUM_W'(cmd_len);
    assign span       = SUM_W'(cmd_offset) + len_ext;
    assign in_beats   = CNT_W'((len_ext + SUM_W'(DMA_PCIS_BYTES - 1)) >> DMA_LANE_W);
    assign out_beats  = CNT_W'((span + SUM_W'(DMA_PCIS_BYTES - 1)) >> DMA_LANE_W);
    assign end_lane_d = DMA_LANE_W'(span - SUM_W'(1));

    // Handshakes; the output register accepts a beat when empty or draining this cycle.
    assign cmd_grant       = (state_q == IDLE);
    assign cmd_fire        = cmd_valid & cmd_grant;
    assign out_free        = ~out_valid_q | packet_out_grant;
    assign packet_in_grant = (state_q == STREAM) & (in_left_q != '0) & out_free;
    assign in_fire         = packet_in_valid & packet_in_grant;

    dma_pcis_byte_rotate u_rotate (
        .data_i (packet_in),
        .amt_i  (offset_q),
        .data_o (rot)
    );

    // Lanes at or above the offset come from the current beat, lanes below from the carry.
    assign hi_strb     = strb_from_lane(offset_q);
    assign hi_mask     = expand_strb(hi_strb);
    assign stream_data = (rot & hi_mask) | (carry_q & ~hi_mask);
    assign stream_strb = (first_q ? hi_strb : '1)
                       & ((out_left_q == CNT_W'(1)) ? strb_upto_lane(end_lane_q) : '1);
    assign flush_data  = carry_q & ~hi_mask;
    assign flush_strb  = strb_upto_lane(end_lane_q);

    // Control FSM together with the command context, carry and output beat register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            offset_q    <= '0;
            end_lane_q  <= '0;
            in_left_q   <= '0;
            out_left_q  <= '0;
            first_q     <= 1'b0;
            carry_q     <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && packet_out_grant) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (cmd_fire && (cmd_len != '0)) begin
                        offset_q   <= cmd_offset;
                        end_lane_q <= end_lane_d;
                        in_left_q  <= in_beats;
                        out_left_q <= out_beats;
                        first_q    <= 1'b1;
                        carry_q    <= '0;
                        state_q    <= STREAM;
                    end
                end
                STREAM: begin
                    if (in_fire) begin
                        out_data_q  <= stream_data;
                        out_strb_q  <= stream_strb;
                        out_last_q  <= (out_left_q == CNT_W'(1));
                        out_valid_q <= 1'b1;
                        carry_q     <= rot;
                        first_q     <= 1'b0;
                        in_left_q   <= in_left_q - CNT_W'(1);
                        out_left_q  <= out_left_q - CNT_W'(1);
                        if (out_left_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                        end else if ((in_left_q == CNT_W'(1)) && (out_left_q == CNT_W'(2))) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        out_data_q  <= flush_data;
                        out_strb_q  <= flush_strb;
                        out_last_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                        out_left_q  <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign packet_out       = out_data_q;
    assign wrstrb_out       = out_strb_q;
    assign packet_out_last  = out_last_q;
    assign packet_out_valid = out_valid_q;

endmodule

// File: tb/tb_dma_pcis_wrstrb_gen.sv
// Scoreboard bench for dma_pcis_wrstrb_gen: a byte-level reference model predicts every output beat.
module tb_dma_pcis_wrstrb_gen;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [5:0]   cmd_offset = '0;
    logic [15:0]  cmd_len = '0;
    logic         cmd_grant;
    logic [511:0] packet_in = '0;
    logic         packet_in_valid = 1'b0;
    logic         packet_in_grant;
    logic [511:0] packet_out;
    logic [63:0]  wrstrb_out;
    logic         packet_out_last;
    logic         packet_out_valid;
    logic         packet_out_grant = 1'b0;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  s;
        logic         l;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        obs_q[$];
    logic [511:0] in_q[$];
    int           checks = 0;
    int           errors = 0;
    int           gmode  = 0;   // 0 grant always, 1 toggle, 2 random, 3 never

    dma_pcis_wrstrb_gen #(.LEN_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_offset       (cmd_offset),
        .cmd_len          (cmd_len),
        .cmd_grant        (cmd_grant),
        .packet_in        (packet_in),
        .packet_in_valid  (packet_in_valid),
        .packet_in_grant  (packet_in_grant),
        .packet_out       (packet_out),
        .wrstrb_out       (wrstrb_out),
        .packet_out_last  (packet_out_last),
        .packet_out_valid (packet_out_valid),
        .packet_out_grant (packet_out_grant)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Output-side grant pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (gmode)
                0: packet_out_grant = 1'b1;
                1: packet_out_grant = ~packet_out_grant;
                2: packet_out_grant = 1'($urandom_range(0, 1));
                default: packet_out_grant = 1'b0;
            endcase
        end
    end

    // Source beat driver: presents the queue head, holds it until consumed.
    initial begin
        bit fired;
        forever begin
            @(negedge clk);
            fired = packet_in_valid && packet_in_grant;
            @(posedge clk);
            #1;
            if (fired && in_q.size() > 0) void'(in_q.pop_front());
            if (in_q.size() > 0) begin
                packet_in       = in_q[0];
                packet_in_valid = 1'b1;
            end else begin
                packet_in_valid = 1'b0;
            end
        end
    end

    // Output monitor: records every beat taken by the consumer.
    always @(negedge clk) begin
        if (!rst && packet_out_valid && packet_out_grant)
            obs_q.push_back('{d: packet_out, s: wrstrb_out, l: packet_out_last});
    end

    function automatic logic [511:0] lane_mask(input logic [63:0] s);
        logic [511:0] m;
        for (int i = 0; i < 64; i++) m[i*8 +: 8] = {8{s[i]}};
        return m;
    endfunction

    // Reference model: stream byte b lands in beat (b+off)/64, lane (b+off)%64.
    task automatic push_xfer(input int off, input int len);
        int           inb;
        int           outb;
        int           idx;
        logic [7:0]   sb[];
        logic [511:0] line;
        beat_t        b;
        inb  = (len + 63) / 64;
        outb = (off + len + 63) / 64;
        sb   = new[inb * 64];
        foreach (sb[j]) sb[j] = 8'($urandom);
        for (int k = 0; k < inb; k++) begin
            for (int i = 0; i < 64; i++) line[i*8 +: 8] = sb[k*64 + i];
            in_q.push_back(line);
        end
        for (int k = 0; k < outb; k++) begin
            b.d = '0;
            b.s = '0;
            b.l = (k == outb - 1);
            for (int i = 0; i < 64; i++) begin
                idx = 64 * k + i - off;
                if (idx >= 0 && idx < len) begin
                    b.s[i]       = 1'b1;
                    b.d[i*8 +: 8] = sb[idx];
                end
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic issue_cmd(input int off, input int len, output int waited);
        @(posedge clk);
        #1;
        cmd_valid  = 1'b1;
        cmd_offset = 6'(off);
        cmd_len    = 16'(len);
        waited     = 0;
        forever begin
            @(negedge clk);
            if (cmd_grant) break;
            waited++;
            if (waited > 3000) break;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (in_q.size() == 0 && obs_q.size() >= exp_q.size() && !packet_out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checks++; if (packet_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", packet_out_valid); end
        checks++; if (packet_out !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", packet_out); end
        checks++; if (wrstrb_out !== '0) begin errors++; $display("FAIL reset_strb got %h exp 0", wrstrb_out); end
        checks++; if (packet_out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", packet_out_last); end
        checks++; if (cmd_grant !== 1'b1) begin errors++; $display("FAIL reset_cmd_grant got %b exp 1", cmd_grant); end
        checks++; if (packet_in_grant !== 1'b0) begin errors++; $display("FAIL reset_in_grant got %b exp 0", packet_in_grant); end
    endtask

    task automatic test_aligned;
        int w; bit ok; beat_t e, g;
        gmode = 0;
        push_xfer(0, 128);
        issue_cmd(0, 128, w);
        wait_drain(ok);
        checks++; if (!ok || obs_q.size() != 2) begin errors++; $display("FAIL aligned_count got %0d exp 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g.s !== e.s || (g.d & lane_mask(e.s)) !== e.d || g.l !== e.l) begin
                errors++; $display("FAIL aligned_beat strb %h exp %h last %b exp %b data %h exp %h", g.s, e.s, g.l, e.l, g.d & lane_mask(e.s), e.d);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_single_offset;
        int w; bit ok; beat_t e, g;
        push_xfer(4, 60);
        issue_cmd(4, 60, w);
        wait_drain(ok);
        checks++; if (!ok || obs_q.size() != 1) begin errors++; $display("FAIL off4_count got %0d exp 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++; if (obs_q[0].s !== 64'hFFFF_FFFF_FFFF_FFF0) begin errors++; $display("FAIL off4_strb got %h exp fffffffffffffff0", obs_q[0].s); end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g.s !== e.s || (g.d & lane_mask(e.s)) !== e.d || g.l !== e.l) begin
                errors++; $display("FAIL off4_beat strb %h exp %h last %b exp %b data %h exp %h", g.s, e.s, g.l, e.l, g.d & lane_mask(e.s), e.d);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_flush;
        int w; bit ok; beat_t e, g;
        push_xfer(60, 8);
        issue_cmd(60, 8, w);
        wait_drain(ok);
        checks++; if (!ok || obs_q.size() != 2) begin errors++; $display("FAIL flush_count got %0d exp 2", obs_q.size()); end
        if (obs_q.size() > 1) begin
            checks++; if (obs_q[0].s !== 64'hF000_0000_0000_0000) begin errors++; $display("FAIL flush_strb0 got %h exp f000000000000000", obs_q[0].s); end
            checks++; if (obs_q[1].s !== 64'h0000_0000_0000_000F) begin errors++; $display("FAIL flush_strb1 got %h exp 000000000000000f", obs_q[1].s); end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g.s !== e.s || (g.d & lane_mask(e.s)) !== e.d || g.l !== e.l) begin
                errors++; $display("FAIL flush_beat strb %h exp %h last %b exp %b data %h exp %h", g.s, e.s, g.l, e.l, g.d & lane_mask(e.s), e.d);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure;
        int w; bit ok; beat_t e, g;
        logic stalled; logic [511:0] pd; logic [63:0] ps; logic pl;
        gmode = 1;
        push_xfer(1, 64);
        issue_cmd(1, 64, w);
        stalled = 1'b0; pd = '0; ps = '0; pl = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (!packet_out_valid || packet_out !== pd || wrstrb_out !== ps || packet_out_last !== pl) begin
                    errors++; $display("FAIL bp_stable valid %b strb %h exp %h last %b exp %b", packet_out_valid, wrstrb_out, ps, packet_out_last, pl);
                end
            end
            stalled = packet_out_valid && !packet_out_grant;
            pd = packet_out; ps = wrstrb_out; pl = packet_out_last;
        end
        wait_drain(ok);
        checks++; if (!ok || obs_q.size() != 2) begin errors++; $display("FAIL bp_count got %0d exp 2", obs_q.size()); end
        if (obs_q.size() > 1) begin
            checks++; if (obs_q[0].s !== 64'hFFFF_FFFF_FFFF_FFFE || obs_q[1].s !== 64'h1) begin
                errors++; $display("FAIL bp_strb got %h %h exp fffffffffffffffe 0000000000000001", obs_q[0].s, obs_q[1].s);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g.s !== e.s || (g.d & lane_mask(e.s)) !== e.d || g.l !== e.l) begin
                errors++; $display("FAIL bp_beat strb %h exp %h last %b exp %b data %h exp %h", g.s, e.s, g.l, e.l, g.d & lane_mask(e.s), e.d);
            end
        end
        exp_q.delete(); obs_q.delete();
        gmode = 0;
    endtask

    task automatic test_zero_len;
        int w; bit ok; bit seen; beat_t e, g;
        issue_cmd(10, 0, w);
        checks++; if (w != 0) begin errors++; $display("FAIL zlen_accept waited %0d exp 0", w); end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (packet_out_valid || !cmd_grant) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL zlen_idle got output/busy %b exp 0", seen); end
        gmode = 2;
        push_xfer(17, 200);
        issue_cmd(17, 200, w);
        wait_drain(ok);
        checks++; if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL zlen_next_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g.s !== e.s || (g.d & lane_mask(e.s)) !== e.d || g.l !== e.l) begin
                errors++; $display("FAIL zlen_beat strb %h exp %h last %b exp %b data %h exp %h", g.s, e.s, g.l, e.l, g.d & lane_mask(e.s), e.d);
            end
        end
        exp_q.delete(); obs_q.delete();
        gmode = 0;
    endtask

    task automatic test_back_to_back;
        int w; bit ok; beat_t e, g;
        int offs[8] = '{0, 63, 5, 60, 0, 1, 37, 32};
        int lens[8] = '{64, 1, 300, 8, 1, 127, 1000, 64};
        gmode = 2;
        for (int t = 0; t < 8; t++) begin
            push_xfer(offs[t], lens[t]);
            issue_cmd(offs[t], lens[t], w);
            checks++; if (w > 3000) begin errors++; $display("FAIL b2b_cmd%0d not granted, waited %0d", t, w); end
        end
        wait_drain(ok);
        checks++; if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g.s !== e.s || (g.d & lane_mask(e.s)) !== e.d || g.l !== e.l) begin
                errors++; $display("FAIL b2b_beat strb %h exp %h last %b exp %b data %h exp %h", g.s, e.s, g.l, e.l, g.d & lane_mask(e.s), e.d);
            end
        end
        exp_q.delete(); obs_q.delete();
        gmode = 0;
    endtask

    task automatic test_mid_reset;
        int w; bit ok; bit got; beat_t e, g;
        gmode = 3;
        push_xfer(8, 160);
        while (in_q.size() > 1) void'(in_q.pop_back());
        issue_cmd(8, 160, w);
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (packet_out_valid) begin got = 1'b1; break; end
        end
        checks++; if (!got) begin errors++; $display("FAIL mrst_beat1 valid %b exp 1", packet_out_valid); end
        checks++; if (cmd_grant !== 1'b0) begin errors++; $display("FAIL mrst_busy cmd_grant %b exp 0", cmd_grant); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (packet_out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b exp 0", packet_out_valid); end
        checks++; if (packet_out !== '0 || wrstrb_out !== '0 || packet_out_last !== 1'b0) begin
            errors++; $display("FAIL mrst_outputs strb %h last %b data %h exp all 0", wrstrb_out, packet_out_last, packet_out);
        end
        in_q.delete(); exp_q.delete(); obs_q.delete();
        gmode = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_grant !== 1'b1 || packet_in_grant !== 1'b0) begin
            errors++; $display("FAIL mrst_idle cmd_grant %b exp 1 in_grant %b exp 0", cmd_grant, packet_in_grant);
        end
        push_xfer(33, 100);
        issue_cmd(33, 100, w);
        wait_drain(ok);
        checks++; if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL mrst_after_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); checks++;
            if (g.s !== e.s || (g.d & lane_mask(e.s)) !== e.d || g.l !== e.l) begin
                errors++; $display("FAIL mrst_after_beat strb %h exp %h last %b exp %b data %h exp %h", g.s, e.s, g.l, e.l, g.d & lane_mask(e.s), e.d);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_single_offset();
        test_flush();
        test_backpressure();
        test_zero_len();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
